store_rmw_seq: RTL and testbench
================================

# store_rmw_seq

Sequential store engine for the multicycle MIPS datapath. It executes sw, sh and sb against a word-wide memory. For sh and sb it does a read-modify-write: it reads the target word, captures it in an internal memory data register, splices the low halfword or byte of the store operand into it, and writes the merged word back. It sits between the B register / control unit and the memory port, and it replaces ad-hoc sequencing of the store-size merge in the control FSM.

## Interface
- READ_LAT, default 1: memory read latency in cycles from the cycle `mem_rd` is high to the cycle `mem_rdata` is valid. Legal range 1..3.

- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- start  in  1  store request; sampled only in IDLE
- size  in  2  01 sw, 10 sh, 11 sb, 00 illegal
- addr  in  32  word address, passed through unmodified (no byte-lane alignment)
- wdata  in  32  store operand (B register value)
- mem_rdata  in  32  memory read data
- mem_addr  out  32  memory address
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_wdata  out  32  memory write data
- mdr_out  out  32  last captured memory word
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse coincident with `done` for illegal `size`

## Operation
- States: IDLE, READ, WAIT, WRITE, DONE. All outputs are registered and decoded from state (Moore behaviour).
- IDLE with `start`=1:
  - latch `addr`, `wdata` and `size`;
  - size 01 → WRITE;
  - size 10/11 → READ;
  - size 00 → DONE with an err flag set.
- READ: `mem_rd`=1, `mem_addr`=latched addr. Next state is WAIT, with the wait counter loaded to READ_LAT-1.
- WAIT: `mem_addr` is held, `mem_rd`=0. The counter decrements each cycle.
  - When the counter reaches 0, capture `mem_rdata` into the MDR on that edge and go to WRITE.
  - WAIT therefore lasts exactly READ_LAT cycles.
- WRITE: `mem_wr`=1, `mem_addr`=latched addr. `mem_wdata` depends on size:
  - sw: wdata;
  - sh: {mdr[31:16], wdata[15:0]};
  - sb: {mdr[31:8], wdata[7:0]}.
  - Next state is DONE.
- DONE: `done`=1, `err`=the err flag, busy=1. Next state is IDLE and the err flag is cleared.
- Input latching:
  - `start` outside IDLE is ignored, including in DONE. It is not queued.
  - Changes to `addr`, `wdata` and `size` after acceptance have no effect.
- Output defaults: `mem_addr` and `mem_wdata` are 0 in states where they are not listed above. `mem_rd` and `mem_wr` are never high together.
- MDR:
  - `mdr_out` holds its value until the next capture.
  - sw and illegal requests do not touch the MDR.
- Illegal size: no memory strobe is ever asserted.

## Timing
- Cycle 0 is the cycle in which `start` is sampled in IDLE.
- sw:
  - WRITE in cycle 1;
  - `done` in cycle 2;
  - IDLE in cycle 3.
- sh/sb:
  - READ in cycle 1;
  - WAIT in cycles 2..1+READ_LAT;
  - WRITE in cycle 2+READ_LAT;
  - `done` in cycle 3+READ_LAT.
  - With READ_LAT=1: `mem_rdata` is sampled at the end of cycle 2, WRITE is in cycle 3 and `done` is in cycle 4.
- Illegal size: `done`=`err`=1 in cycle 1.
- Back-to-back requests: the earliest next acceptance is the first IDLE cycle after DONE.
- Reset:
  - At any edge with `reset`=1: state → IDLE; all outputs, the MDR, the counter, the latches and the err flag → 0.
  - `reset` has priority over `start`.
  - A reset during READ/WAIT/WRITE aborts the operation. `mem_wr`/`mem_rd` are 0 from the cycle after the reset edge. No `done` is produced for the aborted request.

## Test plan
- Reset with `start`=1 held → every output 0, `busy`=0. Deassert reset, start sw → `mem_wr` pulses exactly once.
- sw, addr=0x40, wdata=0x11223344 → cycle 1: `mem_wr`=1, `mem_addr`=0x40, `mem_wdata`=0x11223344. Cycle 2: `done`=1, `err`=0. `mem_rd` is never asserted.
- sh, READ_LAT=1, memory word 0xAABBCCDD, wdata=0x11223344 → `mem_rd` in cycle 1, `mdr_out`=0xAABBCCDD from cycle 3, `mem_wdata`=0xAABB3344 with `mem_wr` in cycle 3, `done` in cycle 4. The same stimulus as sb → `mem_wdata`=0xAABBCC44.
- READ_LAT=3, sb → WAIT lasts 3 cycles, WRITE in cycle 5, `done` in cycle 6. Holding `start`=1 throughout starts a second request only after returning to IDLE (cycle 7).
- size=00 → `done`=`err`=1 in cycle 1. `mem_rd` and `mem_wr` stay 0 and `mdr_out` is unchanged.
- sh with reset asserted in the WAIT cycle → IDLE next cycle. `mem_wr` is never asserted, `done` is never asserted, and `mdr_out`=0.

Source files
------------

// File: rtl/store_rmw_seq.sv
// store_rmw_seq
//   Sequential store engine for the multicycle MIPS datapath. Executes sw
//   directly and sh/sb as read-modify-write: the target word is read into
//   an internal MDR, the low halfword/byte of the store operand is spliced
//   in, and the merged word is written back. All outputs are registered and
//   reflect the current state (Moore).
//
// Ports
//   clk        : clock, all state on rising edge
//   reset      : synchronous, active-high
//   start      : store request, sampled only in IDLE
//   size       : 01 sw, 10 sh, 11 sb, 00 illegal
//   addr       : word address, passed through unmodified
//   wdata      : store operand (B register value)
//   mem_rdata  : memory read data, valid READ_LAT cycles after mem_rd
//   mem_addr   : memory address (0 outside READ/WAIT/WRITE)
//   mem_rd     : memory read strobe (READ)
//   mem_wr     : memory write strobe (WRITE)
//   mem_wdata  : memory write data (0 outside WRITE)
//   mdr_out    : last captured memory word
//   busy       : high in every state except IDLE
//   done       : one-cycle completion pulse
//   err        : one-cycle pulse with done for an illegal size
module store_rmw_seq #(
    parameter int unsigned READ_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic [31:0] mdr_out,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned CW = 2;

    localparam logic [1:0] SZ_W = 2'b01;
    localparam logic [1:0] SZ_H = 2'b10;
    localparam logic [1:0] SZ_B = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [1:0]    size_q, size_d;
    logic          errf_q, errf_d;
    logic [31:0]   mdr_q, mdr_d;

    logic [31:0]   mem_addr_q, mem_addr_d;
    logic          mem_rd_q, mem_rd_d;
    logic          mem_wr_q, mem_wr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    // Next-state, latches and MDR capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        errf_d  = errf_q;
        mdr_d   = mdr_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    size_d  = size;
                    unique case (size)
                        SZ_W:       state_d = S_WRITE;
                        SZ_H, SZ_B: state_d = S_READ;
                        default: begin
                            state_d = S_DONE;
                            errf_d  = 1'b1;
                        end
                    endcase
                end
            end
            S_READ: begin
                state_d = S_WAIT;
                cnt_d   = CW'(READ_LAT - 1);
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    mdr_d   = mem_rdata;
                    state_d = S_WRITE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_WRITE: state_d = S_DONE;
            S_DONE: begin
                state_d = S_IDLE;
                errf_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so that each output is
    // valid during the cycle its state is occupied. The merge uses mdr_d
    // because the MDR capture and entry into WRITE share the same edge.
    always_comb begin
        mem_addr_d  = '0;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_wdata_d = '0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        busy_d      = (state_d != S_IDLE);

        unique case (state_d)
            S_READ: begin
                mem_rd_d   = 1'b1;
                mem_addr_d = addr_d;
            end
            S_WAIT: mem_addr_d = addr_d;
            S_WRITE: begin
                mem_wr_d   = 1'b1;
                mem_addr_d = addr_d;
                unique case (size_d)
                    SZ_H:    mem_wdata_d = {mdr_d[31:16], wdata_d[15:0]};
                    SZ_B:    mem_wdata_d = {mdr_d[31:8], wdata_d[7:0]};
                    default: mem_wdata_d = wdata_d;
                endcase
            end
            S_DONE: begin
                done_d = 1'b1;
                err_d  = errf_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= '0;
            errf_q      <= 1'b0;
            mdr_q       <= '0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            errf_q      <= errf_d;
            mdr_q       <= mdr_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;
    assign mdr_out   = mdr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_store_rmw_seq.sv
// tb_store_rmw_seq
//   Two store_rmw_seq instances (READ_LAT=1 and READ_LAT=3) driven from one
//   directed/randomized sequence. Expectations come from a timeline model of
//   each request plus a word memory and MDR kept in the bench. The memory
//   responder answers READ_LAT cycles after it sees mem_rd and returns
//   random junk in every other cycle.
`timescale 1ns/1ps
module tb_store_rmw_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_s  [2];
    logic        start_s  [2];
    logic [1:0]  size_s   [2];
    logic [31:0] addr_s   [2];
    logic [31:0] wdata_s  [2];
    logic [31:0] rdata_s  [2];
    logic [31:0] maddr_s  [2];
    logic        rd_s     [2];
    logic        wr_s     [2];
    logic [31:0] mwdata_s [2];
    logic [31:0] mdr_s    [2];
    logic        busy_s   [2];
    logic        done_s   [2];
    logic        err_s    [2];

    store_rmw_seq #(.READ_LAT(1)) u_dut_l1 (
        .clk(clk), .reset(reset_s[0]), .start(start_s[0]), .size(size_s[0]),
        .addr(addr_s[0]), .wdata(wdata_s[0]), .mem_rdata(rdata_s[0]),
        .mem_addr(maddr_s[0]), .mem_rd(rd_s[0]), .mem_wr(wr_s[0]),
        .mem_wdata(mwdata_s[0]), .mdr_out(mdr_s[0]), .busy(busy_s[0]),
        .done(done_s[0]), .err(err_s[0])
    );

    store_rmw_seq #(.READ_LAT(3)) u_dut_l3 (
        .clk(clk), .reset(reset_s[1]), .start(start_s[1]), .size(size_s[1]),
        .addr(addr_s[1]), .wdata(wdata_s[1]), .mem_rdata(rdata_s[1]),
        .mem_addr(maddr_s[1]), .mem_rd(rd_s[1]), .mem_wr(wr_s[1]),
        .mem_wdata(mwdata_s[1]), .mdr_out(mdr_s[1]), .busy(busy_s[1]),
        .done(done_s[1]), .err(err_s[1])
    );

    logic [31:0] mem_m [2][16];
    logic [31:0] mdr_m [2];
    logic [31:0] last_wr [2];
    int          wr_cnt;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic int rl(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input int k, input int c, input logic e_rd, input logic e_wr,
                            input logic [31:0] e_ma, input logic [31:0] e_mw,
                            input logic e_busy, input logic e_done, input logic e_err,
                            input logic [31:0] e_mdr);
        chk($sformatf("mem_rd k%0d c%0d", k, c),    32'(rd_s[k]),   32'(e_rd));
        chk($sformatf("mem_wr k%0d c%0d", k, c),    32'(wr_s[k]),   32'(e_wr));
        chk($sformatf("mem_addr k%0d c%0d", k, c),  maddr_s[k],     e_ma);
        chk($sformatf("mem_wdata k%0d c%0d", k, c), mwdata_s[k],    e_mw);
        chk($sformatf("busy k%0d c%0d", k, c),      32'(busy_s[k]), 32'(e_busy));
        chk($sformatf("done k%0d c%0d", k, c),      32'(done_s[k]), 32'(e_done));
        chk($sformatf("err k%0d c%0d", k, c),       32'(err_s[k]),  32'(e_err));
        chk($sformatf("mdr_out k%0d c%0d", k, c),   mdr_s[k],       e_mdr);
    endtask

    task automatic drive_garbage(input int k, input logic st);
        start_s[k] = st;
        size_s[k]  = 2'($urandom);
        addr_s[k]  = $urandom;
        wdata_s[k] = $urandom;
    endtask

    // Entered and left at the negedge of an IDLE cycle (that cycle is the
    // request's cycle 0). abort_c > 0 asserts reset during that cycle.
    task automatic run_req(input int k, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] w, input bit hold, input int abort_c);
        int          lat;
        bit          legal, rmw;
        logic [31:0] old, expw, mdr_before, pend_a;
        int          wc, dc, pend_t;
        logic        e_rd, e_wt, e_wr;
        lat        = rl(k);
        legal      = (sz != 2'b00);
        rmw        = sz[1];
        old        = mem_m[k][a[3:0]];
        mdr_before = mdr_m[k];
        case (sz)
            2'b01:   expw = w;
            2'b10:   expw = {old[31:16], w[15:0]};
            default: expw = {old[31:8], w[7:0]};
        endcase
        wc     = !legal ? -1 : (rmw ? 2 + lat : 1);
        dc     = !legal ? 1 : (rmw ? 3 + lat : 2);
        pend_t = -1;
        pend_a = '0;

        chk($sformatf("busy k%0d c0", k), 32'(busy_s[k]), 32'h0);
        start_s[k] = 1'b1;
        size_s[k]  = sz;
        addr_s[k]  = a;
        wdata_s[k] = w;
        rdata_s[k] = $urandom;

        for (int c = 1; c <= dc; c++) begin
            @(negedge clk);
            e_rd = rmw && (c == 1);
            e_wt = rmw && (c >= 2) && (c <= 1 + lat);
            e_wr = (c == wc);
            chk_outs(k, c, e_rd, e_wr, (e_rd || e_wt || e_wr) ? a : 32'h0,
                     e_wr ? expw : 32'h0, 1'b1, c == dc, (c == dc) && !legal,
                     (rmw && c >= wc) ? old : mdr_before);
            if (wr_s[k] === 1'b1) begin
                wr_cnt++;
                last_wr[k] = mwdata_s[k];
            end
            if (rd_s[k] === 1'b1) begin
                pend_t = c + lat;
                pend_a = maddr_s[k];
            end
            rdata_s[k] = (c == pend_t) ? mem_m[k][pend_a[3:0]] : $urandom;
            if (c == abort_c) begin
                reset_s[k] = 1'b1;
                @(negedge clk);
                reset_s[k] = 1'b0;
                start_s[k] = 1'b0;
                if (legal && c >= wc) mem_m[k][a[3:0]] = expw;
                mdr_m[k] = '0;
                chk_outs(k, c + 1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
                return;
            end
            drive_garbage(k, hold ? 1'b1 : 1'($urandom));
        end
        if (legal) mem_m[k][a[3:0]] = expw;
        if (rmw) mdr_m[k] = old;
        @(negedge clk);
        chk_outs(k, dc + 1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, mdr_m[k]);
        if (!hold) start_s[k] = 1'b0;
        rdata_s[k] = $urandom;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k, dc, ab;
        logic [1:0]  sz;
        for (int j = 0; j < 2; j++) begin
            reset_s[j] = 1'b1;
            start_s[j] = 1'b1;
            size_s[j]  = 2'b01;
            addr_s[j]  = $urandom;
            wdata_s[j] = $urandom;
            rdata_s[j] = $urandom;
            mdr_m[j]   = '0;
            last_wr[j] = '0;
            for (int i = 0; i < 16; i++) mem_m[j][i] = $urandom;
        end
        wr_cnt = 0;

        // Reset with start held: everything zero.
        repeat (3) begin
            @(negedge clk);
            for (int j = 0; j < 2; j++)
                chk_outs(j, 0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        end
        reset_s[0] = 1'b0;
        reset_s[1] = 1'b0;
        start_s[1] = 1'b0;

        // sw: single write pulse, no read.
        run_req(0, 2'b01, 32'h40, 32'h11223344, 1'b0, 0);
        chk("sw write pulses", 32'(wr_cnt), 32'd1);
        chk("sw write data", last_wr[0], 32'h11223344);

        // sh / sb merge with READ_LAT=1.
        mem_m[0][4] = 32'hAABBCCDD;
        run_req(0, 2'b10, 32'h44, 32'h11223344, 1'b0, 0);
        chk("sh merged word", last_wr[0], 32'hAABB3344);
        chk("sh mdr", mdr_s[0], 32'hAABBCCDD);
        mem_m[0][4] = 32'hAABBCCDD;
        run_req(0, 2'b11, 32'h44, 32'h11223344, 1'b0, 0);
        chk("sb merged word", last_wr[0], 32'hAABBCC44);

        // READ_LAT=3 sb with start held; second request accepted in cycle 7.
        run_req(1, 2'b11, 32'h1008, $urandom, 1'b1, 0);
        run_req(1, 2'b01, 32'h200C, $urandom, 1'b0, 0);

        // Illegal size: done+err in cycle 1, MDR untouched.
        run_req(0, 2'b00, 32'h5, 32'h55AA55AA, 1'b0, 0);
        chk("illegal mdr kept", mdr_s[0], 32'hAABBCCDD);

        // Reset during WAIT aborts sh.
        wr_cnt = 0;
        run_req(0, 2'b10, 32'h44, 32'h99887766, 1'b0, 2);
        run_req(1, 2'b10, 32'h3, 32'h12345678, 1'b0, 3);
        chk("abort write pulses", 32'(wr_cnt), 32'd0);

        // Randomized requests.
        for (int i = 0; i < 160; i++) begin
            k  = int'($urandom_range(0, 1));
            sz = 2'($urandom);
            dc = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 3 + rl(k);
            ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, dc)) : 0;
            start_s[1 - k] = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                start_s[0] = 1'b0;
                start_s[1] = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
            end
            run_req(k, sz, $urandom, $urandom, ($urandom_range(0, 5) == 0), ab);
        end

        // Final reset with start held after activity.
        for (int j = 0; j < 2; j++) begin
            reset_s[j] = 1'b1;
            start_s[j] = 1'b1;
            size_s[j]  = 2'b10;
            mdr_m[j]   = '0;
        end
        @(negedge clk);
        for (int j = 0; j < 2; j++)
            chk_outs(j, 0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int j = 0; j < 2; j++) begin
            reset_s[j] = 1'b0;
            start_s[j] = 1'b0;
        end
        run_req(1, 2'b10, 32'h7, 32'hCAFEF00D, 1'b0, 0);
        run_req(0, 2'b11, 32'h9, 32'h0BADBEEF, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
